// File: rtl/persp_divide_array.sv
// rtl/persp_divide_array.sv - batch perspective divide (x/w, y/w) over NUM_VTX vertices with one shared sequential divider
module persp_divide_array #(
    parameter int DATA_W    = 21,
    parameter int NUM_VTX   = 4,
    parameter int FRAC_BITS = 0
) (
    input  logic                        CLK,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_VTX*DATA_W-1:0]   x_in,
    input  logic [NUM_VTX*DATA_W-1:0]   y_in,
    input  logic [NUM_VTX*DATA_W-1:0]   w_in,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_VTX*DATA_W-1:0]   vtx_x_out,
    output logic [NUM_VTX*DATA_W-1:0]   vtx_y_out,
    output logic [NUM_VTX*DATA_W-1:0]   vtx_z_out,
    output logic [NUM_VTX-1:0]          div0_flag
);
    localparam int N  = DATA_W + FRAC_BITS;
    localparam int NE = 2 * NUM_VTX;
    localparam int EW = (NE > 2) ? $clog2(NE) : 1;
    localparam int CW = $clog2(N);
    localparam int VW = NUM_VTX * DATA_W;

    localparam logic [N-1:0]      LIM  = N'(64'd1 << (DATA_W - 1));
    localparam logic [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, DIV, STORE, DONE} state_t;

    state_t               state;
    logic [VW-1:0]        x_snap, y_snap, w_snap;
    logic [NE*DATA_W-1:0] res;
    logic [EW-1:0]        e;
    logic [CW-1:0]        cnt;
    logic [N-1:0]         dvd;
    logic [N-1:0]         quo;
    logic [DATA_W-1:0]    dvs;
    logic [DATA_W-1:0]    rem;
    logic                 neg, a_neg, w_zero;

    int                   vk;
    logic [DATA_W-1:0]    a_sel, w_sel, a_mag, w_mag, val;
    logic [DATA_W:0]      rem_shift;
    logic                 sub_ok;
    logic [NE*DATA_W-1:0] res_next;
    logic [VW-1:0]        nx, ny;
    logic [NUM_VTX-1:0]   nflag;

    always_comb begin
        vk        = int'(e) >> 1;
        a_sel     = e[0] ? y_snap[vk*DATA_W +: DATA_W] : x_snap[vk*DATA_W +: DATA_W];
        w_sel     = w_snap[vk*DATA_W +: DATA_W];
        a_mag     = a_sel[DATA_W-1] ? -a_sel : a_sel;
        w_mag     = w_sel[DATA_W-1] ? -w_sel : w_sel;
        rem_shift = {rem, dvd[N-1]};
        sub_ok    = rem_shift >= {1'b0, dvs};

        // w = 0 forces the rail matching the sign of the numerator
        if (w_zero)
            val = a_neg ? MINV : MAXV;
        else if (neg)
            val = (quo > LIM) ? MINV : -quo[DATA_W-1:0];
        else
            val = (quo >= LIM) ? MAXV : quo[DATA_W-1:0];

        res_next = res;
        res_next[int'(e)*DATA_W +: DATA_W] = val;

        nx    = '0;
        ny    = '0;
        nflag = '0;
        for (int k = 0; k < NUM_VTX; k++) begin
            nx[k*DATA_W +: DATA_W] = res_next[(2*k)*DATA_W +: DATA_W];
            ny[k*DATA_W +: DATA_W] = res_next[(2*k+1)*DATA_W +: DATA_W];
            nflag[k]               = (w_snap[k*DATA_W +: DATA_W] == '0);
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            x_snap    <= '0;
            y_snap    <= '0;
            w_snap    <= '0;
            res       <= '0;
            e         <= '0;
            cnt       <= '0;
            dvd       <= '0;
            quo       <= '0;
            dvs       <= '0;
            rem       <= '0;
            neg       <= 1'b0;
            a_neg     <= 1'b0;
            w_zero    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            vtx_x_out <= '0;
            vtx_y_out <= '0;
            vtx_z_out <= '0;
            div0_flag <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    x_snap <= x_in;
                    y_snap <= y_in;
                    w_snap <= w_in;
                    e      <= '0;
                    busy   <= 1'b1;
                    state  <= LOAD;
                end
                LOAD: begin
                    dvd    <= N'(a_mag) << FRAC_BITS;
                    dvs    <= w_mag;
                    neg    <= a_sel[DATA_W-1] ^ w_sel[DATA_W-1];
                    a_neg  <= a_sel[DATA_W-1];
                    w_zero <= (w_sel == '0);
                    rem    <= '0;
                    cnt    <= '0;
                    state  <= DIV;
                end
                DIV: begin
                    rem <= sub_ok ? DATA_W'(rem_shift - {1'b0, dvs}) : rem_shift[DATA_W-1:0];
                    quo <= {quo[N-2:0], sub_ok};
                    dvd <= dvd << 1;
                    if (cnt == CW'(N - 1))
                        state <= STORE;
                    else
                        cnt <= cnt + 1'b1;
                end
                STORE: begin
                    res <= res_next;
                    if (e == EW'(NE - 1)) begin
                        // outputs commit together with the done pulse of the DONE cycle
                        vtx_x_out <= nx;
                        vtx_y_out <= ny;
                        vtx_z_out <= w_snap;
                        div0_flag <= nflag;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        e     <= e + 1'b1;
                        state <= LOAD;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_persp_divide_array.sv
// tb/tb_persp_divide_array.sv - directed bench for persp_divide_array
module tb_persp_divide_array;
    localparam int DW = 21;
    localparam int NV = 4;
    localparam int VW = NV * DW;

    logic          CLK = 1'b0;
    logic          rst;
    logic          s0, s8;
    logic [VW-1:0] xi, yi, wi;
    logic          b0, d0, b8, d8;
    logic [VW-1:0] x0o, y0o, z0o, x8o, y8o, z8o;
    logic [NV-1:0] f0, f8;

    int ncmp = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    persp_divide_array #(.DATA_W(DW), .NUM_VTX(NV), .FRAC_BITS(0)) dut0 (
        .CLK(CLK), .rst(rst), .start(s0), .x_in(xi), .y_in(yi), .w_in(wi),
        .busy(b0), .done(d0), .vtx_x_out(x0o), .vtx_y_out(y0o), .vtx_z_out(z0o),
        .div0_flag(f0));

    persp_divide_array #(.DATA_W(DW), .NUM_VTX(NV), .FRAC_BITS(8)) dut8 (
        .CLK(CLK), .rst(rst), .start(s8), .x_in(xi), .y_in(yi), .w_in(wi),
        .busy(b8), .done(d8), .vtx_x_out(x8o), .vtx_y_out(y8o), .vtx_z_out(z8o),
        .div0_flag(f8));

    task automatic chk(input string tag, input longint obs, input longint exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic longint fld(input logic [VW-1:0] v, input int k);
        logic signed [DW-1:0] s;
        s = v[k*DW +: DW];
        return longint'(s);
    endfunction

    task automatic set_v(input int k, input int x, input int y, input int w);
        xi[k*DW +: DW] = x[DW-1:0];
        yi[k*DW +: DW] = y[DW-1:0];
        wi[k*DW +: DW] = w[DW-1:0];
    endtask

    task automatic clear_v();
        for (int k = 0; k < NV; k++) set_v(k, 0, 0, 1);
    endtask

    task automatic go(input bit sel, input bit hold);
        @(negedge CLK);
        if (sel) s8 = 1'b1; else s0 = 1'b1;
        @(posedge CLK);
        #1;
        if (!hold) begin
            s0 = 1'b0;
            s8 = 1'b0;
        end
    endtask

    task automatic wait_done(input bit sel, input int elapsed, input int exp,
                             input bit cb, input string tag);
        int cnt;
        bit seen;
        cnt  = elapsed;
        seen = 1'b0;
        while (cnt < 600 && !seen) begin
            @(negedge CLK);
            cnt++;
            if (cb && cnt == 1) chk({tag, "_busy"}, sel ? b8 : b0, 1);
            seen = sel ? d8 : d0;
        end
        chk({tag, "_lat"}, seen ? cnt : -1, exp);
    endtask

    task automatic post_done(input bit sel, input string tag);
        @(negedge CLK);
        chk({tag, "_done_pulse"}, sel ? d8 : d0, 0);
        chk({tag, "_busy_fall"}, sel ? b8 : b0, 0);
    endtask

    initial begin
        int hits;
        rst = 1'b1;
        s0  = 1'b0;
        s8  = 1'b0;
        xi  = '0;
        yi  = '0;
        wi  = '0;
        repeat (2) @(negedge CLK);
        chk("rst_busy", b0, 0);
        chk("rst_done", d0, 0);
        chk("rst_out0", (x0o == '0) && (y0o == '0) && (z0o == '0) && (f0 == '0), 1);
        chk("rst_out8", (x8o == '0) && (y8o == '0) && (z8o == '0) && (f8 == '0) && !b8 && !d8, 1);
        rst = 1'b0;

        // basic divide
        clear_v();
        set_v(0, 1000, -300, 10);
        go(0, 0);
        wait_done(0, 0, 185, 1, "basic");
        chk("basic_x0", fld(x0o, 0), 100);
        chk("basic_y0", fld(y0o, 0), -30);
        chk("basic_z0", fld(z0o, 0), 10);
        chk("basic_x1", fld(x0o, 1), 0);
        chk("basic_z3", fld(z0o, 3), 1);
        chk("basic_flag", f0, 0);
        post_done(0, "basic");

        // truncation, signs, most-negative numerator, start ignored while busy
        set_v(0, -1048576, 1048575, 1);
        set_v(1, -7, 7, 2);
        set_v(2, -1048576, 100, -1);
        set_v(3, 7, -7, -2);
        go(0, 0);
        xi = '1;
        yi = '0;
        wi = '0;
        repeat (20) @(negedge CLK);
        s0 = 1'b1;
        @(posedge CLK);
        #1;
        s0 = 1'b0;
        wait_done(0, 20, 185, 0, "trunc");
        chk("trunc_x0", fld(x0o, 0), -1048576);
        chk("trunc_y0", fld(y0o, 0), 1048575);
        chk("trunc_x1", fld(x0o, 1), -3);
        chk("trunc_y1", fld(y0o, 1), 3);
        chk("trunc_x2", fld(x0o, 2), 1048575);
        chk("trunc_y2", fld(y0o, 2), -100);
        chk("trunc_x3", fld(x0o, 3), -3);
        chk("trunc_y3", fld(y0o, 3), 3);
        chk("trunc_z3", fld(z0o, 3), -2);
        post_done(0, "trunc");

        // outputs hold while inputs toggle and no start
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            xi = VW'({$urandom(), $urandom(), $urandom()});
            yi = VW'({$urandom(), $urandom(), $urandom()});
            wi = VW'({$urandom(), $urandom(), $urandom()});
            if (fld(x0o, 1) != -3 || fld(y0o, 2) != -100 || d0 || b0) hits++;
        end
        chk("hold_stable", hits, 0);

        // divide by zero
        clear_v();
        set_v(2, 5, -5, 0);
        go(0, 0);
        wait_done(0, 0, 185, 1, "div0");
        chk("div0_x2", fld(x0o, 2), 1048575);
        chk("div0_y2", fld(y0o, 2), -1048576);
        chk("div0_z2", fld(z0o, 2), 0);
        chk("div0_flag", f0, 4);
        chk("div0_x0", fld(x0o, 0), 0);

        // fixed-point scaling and saturation
        clear_v();
        set_v(0, 3, -3, 2);
        set_v(1, 1048575, -1048576, 1);
        go(1, 0);
        wait_done(1, 0, 249, 1, "frac");
        chk("frac_x0", fld(x8o, 0), 384);
        chk("frac_y0", fld(y8o, 0), -384);
        chk("frac_x1", fld(x8o, 1), 1048575);
        chk("frac_y1", fld(y8o, 1), -1048576);
        chk("frac_flag", f8, 0);
        chk("frac_other_dut", fld(x0o, 2), 1048575);
        post_done(1, "frac");

        // start held high: back-to-back batches
        clear_v();
        set_v(0, 1000, -300, 10);
        go(0, 1);
        wait_done(0, 0, 185, 1, "b2b_first");
        wait_done(0, 0, 186, 0, "b2b_second");
        s0 = 1'b0;
        chk("b2b_x0", fld(x0o, 0), 100);
        chk("b2b_flag", f0, 0);
        post_done(0, "b2b");

        // asynchronous reset in the middle of a batch
        set_v(0, 2000, 400, 20);
        go(0, 0);
        repeat (50) @(negedge CLK);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", b0, 0);
        chk("mid_rst_done", d0, 0);
        chk("mid_rst_out", (x0o == '0) && (y0o == '0) && (z0o == '0) && (f0 == '0), 1);
        repeat (3) @(negedge CLK);
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (d0 || b0 || x0o != '0) hits++;
        end
        chk("mid_rst_quiet", hits, 0);
        go(0, 0);
        wait_done(0, 0, 185, 1, "after_rst");
        chk("after_rst_x0", fld(x0o, 0), 100);
        chk("after_rst_y0", fld(y0o, 0), 20);
        chk("after_rst_z0", fld(z0o, 0), 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
